// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one operand bit per cycle, then a sign-fix cycle and a one-cycle done pulse.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [2:0] OP_MUL = 3'b000;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_REM = 3'b110;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [4:0]        rd_pend_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_q;

    logic              a_signed, b_signed, a_neg, b_neg, neg_d;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              special;
    logic [XLEN-1:0]   special_res;

    // Accept-time decode: operand magnitudes, result sign, early-out cases.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == OP_DIV) || (funct3 == OP_REM);
        b_signed    = (funct3 == 3'b001) || (funct3 == OP_DIV) || (funct3 == OP_REM);
        a_neg       = a_signed & rs1_data[XLEN-1];
        b_neg       = b_signed & rs2_data[XLEN-1];
        a_mag       = a_neg ? -rs1_data : rs1_data;
        b_mag       = b_neg ? -rs2_data : rs2_data;
        neg_d       = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        special     = 1'b0;
        special_res = '0;
        if (funct3[2]) begin
            if (rs2_data == '0) begin
                special     = 1'b1;
                special_res = funct3[1] ? rs1_data : '1;
            end else if (!funct3[0] && rs1_data == INT_MIN && rs2_data == '1) begin
                special     = 1'b1;
                special_res = funct3[1] ? '0 : INT_MIN;
            end
        end
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_trial;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_trial = {1'b0, div_shift} - {2'b00, b_q};
        if (op_q[2]) begin
            step_acc = div_trial[XLEN+1] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                         : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            step_acc = {mul_sum, acc_q[XLEN-1:1]};
        end

        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                  fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011:  fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, 3'b101:          fix_res = quo;
            default:                 fix_res = rem;
        endcase
    end

    // NOTE: sequential state is assigned with <= only, so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
            rd_pend_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q      <= funct3;
                        neg_q     <= neg_d;
                        b_q       <= b_mag;
                        acc_q     <= {{XLEN{1'b0}}, a_mag};
                        rd_pend_q <= rd_in;
                        cnt_q     <= '0;
                        if (special) begin
                            result_q <= special_res;
                            rd_q     <= rd_in;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q <= fix_res;
                    rd_q     <= rd_pend_q;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int si, sj;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        si = a;
        sj = b;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(si / sj);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(si % sj);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Drive a request for one edge, then scramble the inputs; returns at cycle 1.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    endtask

    task automatic wait_done(output int cyc, output bit saw_busy);
        cyc = 1;
        saw_busy = 1'b0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) saw_busy = 1'b1;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int cyc;
        bit saw_busy;
        bit sp;
        sp = is_special(f, a, b);
        launch(f, a, b, rd);
        wait_done(cyc, saw_busy);
        check({tag, "_latency"}, 64'(cyc), sp ? 64'd1 : 64'd34);
        check({tag, "_busy_seen"}, 64'(saw_busy), 64'(!sp));
        check({tag, "_result"}, 64'(result), 64'(exp));
        check({tag, "_rd"}, 64'(rd_out), 64'(rd));
        check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int cyc, pulses, pulse_cyc;
        bit saw_busy;
        logic [31:0] res_at_pulse;
        logic [4:0]  rd_at_pulse;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        logic [31:0] corner [6];

        reset = 1'b0; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_rd", 64'(rd_out), 64'd0);
        reset = 1'b1;

        // Idle funct3/operand wiggle without start must not trigger anything.
        funct3 = 3'd4; rs1_data = 32'd9; rs2_data = 32'd0;
        repeat (3) @(negedge clk);
        check("idle_no_done", 64'(done), 64'd0);
        check("idle_no_busy", 64'(busy), 64'd0);

        do_op("mul_neg",   3'd0, 32'hFFFF_FFFD, 32'd5, 5'd1, 32'hFFFF_FFF1);
        do_op("mulhu",     3'd3, 32'hFFFF_FFFD, 32'd5, 5'd2, 32'h0000_0004);
        do_op("mulh",      3'd1, 32'hFFFF_FFFD, 32'd5, 5'd3, 32'hFFFF_FFFF);
        do_op("div_neg",   3'd4, 32'hFFFF_FFEC, 32'd3, 5'd7, 32'hFFFF_FFFA);
        do_op("rem_neg",   3'd6, 32'hFFFF_FFEC, 32'd3, 5'd7, 32'hFFFF_FFFE);
        do_op("divu",      3'd5, 32'd20, 32'd3, 5'd8, 32'd6);
        do_op("remu",      3'd7, 32'd20, 32'd3, 5'd9, 32'd2);
        do_op("div_by0",   3'd4, 32'd44, 32'd0, 5'd10, 32'hFFFF_FFFF);
        do_op("remu_by0",  3'd7, 32'd44, 32'd0, 5'd11, 32'd44);
        do_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
        do_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0);

        // Start while busy is ignored: exactly one done, from the first op.
        launch(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
        repeat (4) @(negedge clk);
        start = 1'b1; funct3 = 3'd5; rs1_data = 32'd90; rs2_data = 32'd10; rd_in = 5'd4;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; pulse_cyc = 0; res_at_pulse = '0; rd_at_pulse = '0;
        for (int c = 6; c < 80; c++) begin
            if (done === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    pulse_cyc = c; res_at_pulse = result; rd_at_pulse = rd_out;
                end
            end
            @(negedge clk);
        end
        check("busy_start_pulses", 64'(pulses), 64'd1);
        check("busy_start_latency", 64'(pulse_cyc), 64'd34);
        check("busy_start_result", 64'(res_at_pulse), 64'hFFFF_FFFF);
        check("busy_start_rd", 64'(rd_at_pulse), 64'd3);

        // Back-to-back: second start in the DONE cycle of the first.
        launch(3'd6, 32'd23, 32'd4, 5'd14);
        wait_done(cyc, saw_busy);
        check("b2b_first_latency", 64'(cyc), 64'd34);
        check("b2b_first_result", 64'(result), 64'd3);
        check("b2b_first_rd", 64'(rd_out), 64'd14);
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd12; rs2_data = 32'd20; rd_in = 5'd15;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, saw_busy);
        check("b2b_second_latency_total", 64'(34 + cyc), 64'd68);
        check("b2b_second_result", 64'(result), 64'd240);
        check("b2b_second_rd", 64'(rd_out), 64'd15);
        @(negedge clk);
        check("b2b_single_pulse", 64'(done), 64'd0);

        // Reset mid-operation discards the op and clears the outputs.
        do_op("pre_reset_mul", 3'd0, 32'd7, 32'd6, 5'd20, 32'd42);
        launch(3'd0, 32'd3, 32'd2, 5'd9);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_result", 64'(result), 64'd0);
        check("midreset_rd", 64'(rd_out), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        check("midreset_no_done", 64'(pulses), 64'd0);
        do_op("post_reset_mul", 3'd0, 32'd3, 32'd2, 5'd9, 32'd6);

        // Randomized operations against the reference model.
        corner[0] = 32'h0;          corner[1] = 32'h1;
        corner[2] = 32'hFFFF_FFFF;  corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;  corner[5] = 32'hFFFF_FFFE;
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 28);
            do_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, 5'($urandom), model(rf, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Consumes the two register read-data words and the destination register index for an M-extension instruction.
- Computes the result over multiple cycles, then produces a one-cycle done pulse with result and Rd. The writeback path uses that pulse as RegWrite/Write_data/Rd.
- Control holds the pipeline while busy is high.

Parameters:
- XLEN, 32: operand/result width; only 32 is supported.
- CNT_W, 6: iteration counter width; must hold the value XLEN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; asserted when 0
- start  input  1  request; sampled only when the unit can accept
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  input  32  operand A (register Read_data1)
- rs2_data  input  32  operand B (register Read_data2)
- rd_in  input  5  destination register index
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result and rd_out are valid in this cycle
- result  output  32  operation result
- rd_out  output  5  destination index captured at accept

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - state=IDLE.
  - busy=0, done=0, result=0, rd_out=0.
  - Counter and all internal registers are cleared.
  - An in-flight operation is discarded and never signals done.
- States: IDLE, RUN, FIX, DONE.
- Accept condition: state is IDLE or DONE and start=1. On that clk edge the unit latches funct3, rs1_data, rs2_data and rd_in.
  - start in RUN or FIX is ignored; there is no queueing.
- Operand signedness:
  - Operand A is signed for MULH, MULHSU, DIV, REM.
  - Operand B is signed for MULH, DIV, REM.
  - Signed operands are converted to magnitudes at accept. Result sign is recorded: product sign = signA XOR signB; quotient sign = signA XOR signB; remainder sign = signA.
- Special cases, detected at accept (go straight to DONE; done is high in the cycle after the accept edge, latency 1):
  - DIV/DIVU with B=0: quotient = 0xFFFFFFFF.
  - REM/REMU with B=0: remainder = A, unmodified.
  - DIV with A=0x80000000, B=0xFFFFFFFF: quotient = 0x80000000.
  - REM with A=0x80000000, B=0xFFFFFFFF: remainder = 0.
- Normal path:
  - Accept → RUN with counter=0, busy=1.
  - RUN performs one step per cycle for exactly XLEN cycles:
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract with a 33-bit partial remainder.
  - Counter increments each RUN cycle. When counter=XLEN-1 at a clock edge, the next state is FIX.
  - FIX, one cycle:
    - Apply two's-complement sign correction to the 64-bit product, quotient or remainder.
    - Select low 32 bits for MUL and high 32 bits for MULH, MULHSU, MULHU.
    - Write result and rd_out.
    - Next state is DONE.
  - DONE, one cycle: done=1, busy=0. Next state is IDLE, or RUN (or DONE for a special case) if start=1.
  - Total latency, normal path: accept edge at cycle 0 → done high in cycle XLEN+2 (34).
- busy is 1 in RUN and FIX only; 0 in IDLE and DONE.
- done is 1 in DONE only, for exactly one cycle per accepted operation.
- result and rd_out hold their last values until the next FIX or special-case completion. They are not cleared by leaving DONE.
- Back-to-back: start in the DONE cycle is accepted, so the next operation's done follows 34 cycles later. No done pulse is lost or duplicated.
- Operand inputs may change freely after accept; only latched copies are used.
- A start with funct3 held across IDLE cycles while start=0 has no effect.

Test Plan:
- Reset mid-operation: MUL 3×2 accepted, reset=0 at cycle 10 → busy=0, done never pulses, result=0. After release, IDLE accepts a new start.
- MUL A=0xFFFFFFFD (-3), B=5 → done at cycle 34, result=0xFFFFFFF1. MULHU on the same operands → result=0x00000004. MULH on the same operands → result=0xFFFFFFFF.
- DIV A=-20 (0xFFFFFFEC), B=3, rd_in=7:
  - Quotient → result=0xFFFFFFFA, rd_out=7.
  - REM on the same operands → 0xFFFFFFFE.
  - DIVU 20/3 → 6; REMU 20/3 → 2.
- Special cases, each with done one cycle after accept and busy never set:
  - DIV 44/0 → 0xFFFFFFFF.
  - REMU 44/0 → 44.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Start while busy: MULHSU A=0xFFFFFFFF, B=2 running; pulse start with DIVU 90/10 at cycle 5 → ignored; single done with result=0xFFFFFFFF.
- Back-to-back: REM 23/4 followed by start in its DONE cycle with MUL 12×20 → done pulses at cycles 34 and 68, results 3 then 240, with rd_out of each operation.
